// File: rtl/key_map_table.sv
// Note-key remap table: KEYS one-hot entries mapping a played key to the note it sounds,
// with checked read/write, atomic two-entry swap, sequential restore and a duplicate flag.
module key_map_table #(
  parameter int KEYS = 7
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      req_op,
  input  logic [KEYS-1:0] req_key,
  input  logic [KEYS-1:0] req_data,
  output logic            rsp_valid,
  output logic [KEYS-1:0] rsp_data,
  output logic            rsp_err,
  output logic            busy,
  output logic            dup_flag
);

  localparam int IW = $clog2(KEYS);

  typedef enum logic [1:0] {IDLE, SWAP, RESTORE} state_t;
  typedef enum logic [1:0] {
    OP_READ    = 2'b00,
    OP_WRITE   = 2'b01,
    OP_SWAP    = 2'b10,
    OP_RESTORE = 2'b11
  } op_t;

  function automatic logic is_onehot(input logic [KEYS-1:0] v);
    return (v != '0) && ((v & (v - KEYS'(1))) == '0);
  endfunction

  function automatic logic [IW-1:0] oh2idx(input logic [KEYS-1:0] v);
    logic [IW-1:0] idx;
    idx = '0;
    for (int i = 0; i < KEYS; i++) begin
      if (v[i]) idx = IW'(i);
    end
    return idx;
  endfunction

  state_t          state, state_n;
  logic [KEYS-1:0] mem [KEYS];
  logic [IW-1:0]   a_idx, b_idx, r_idx;
  logic [IW-1:0]   key_idx, data_idx;
  logic            key_ok, data_ok, accept, req_bad, restore_last, dup_now;
  op_t             op;

  assign op           = op_t'(req_op);
  assign key_ok       = is_onehot(req_key);
  assign data_ok      = is_onehot(req_data);
  assign key_idx      = oh2idx(req_key);
  assign data_idx     = oh2idx(req_data);
  assign req_ready    = (state == IDLE) & ~rst;
  assign busy         = (state != IDLE);
  assign accept       = req_valid & req_ready;
  assign restore_last = (r_idx == IW'(KEYS - 1));
  assign req_bad      = ((op != OP_RESTORE) && !key_ok) ||
                        (((op == OP_WRITE) || (op == OP_SWAP)) && !data_ok);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // NOTE: every variable written in a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (accept && !req_bad) begin
          if (op == OP_SWAP)         state_n = SWAP;
          else if (op == OP_RESTORE) state_n = RESTORE;
        end
      end
      SWAP:    state_n = IDLE;
      RESTORE: if (restore_last) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Any two equal entries mean the table no longer maps keys one-to-one.
  always_comb begin
    dup_now = 1'b0;
    for (int i = 0; i < KEYS; i++) begin
      for (int j = i + 1; j < KEYS; j++) begin
        if (mem[i] == mem[j]) dup_now = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the table itself is reset because identity mapping is the defined power-up contents, not a don't-care.
      for (int i = 0; i < KEYS; i++) mem[i] <= KEYS'(1) << i;
      a_idx     <= '0;
      b_idx     <= '0;
      r_idx     <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      dup_flag  <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      dup_flag  <= dup_now;
      case (state)
        IDLE: begin
          if (accept) begin
            if (req_bad) begin
              rsp_valid <= 1'b1;
              rsp_data  <= '0;
              rsp_err   <= 1'b1;
            end else begin
              case (op)
                OP_READ: begin
                  rsp_valid <= 1'b1;
                  rsp_data  <= mem[key_idx];
                  rsp_err   <= 1'b0;
                end
                OP_WRITE: begin
                  mem[key_idx] <= req_data;
                  rsp_valid    <= 1'b1;
                  rsp_data     <= req_data;
                  rsp_err      <= 1'b0;
                end
                OP_SWAP: begin
                  a_idx <= key_idx;
                  b_idx <= data_idx;
                end
                default: r_idx <= '0;
              endcase
            end
          end
        end
        SWAP: begin
          // NOTE: non-blocking assignments read both old entries before either is updated, which makes the exchange atomic.
          mem[a_idx] <= mem[b_idx];
          mem[b_idx] <= mem[a_idx];
          rsp_valid  <= 1'b1;
          rsp_data   <= mem[a_idx];
          rsp_err    <= 1'b0;
        end
        RESTORE: begin
          mem[r_idx] <= KEYS'(1) << r_idx;
          r_idx      <= r_idx + IW'(1);
          if (restore_last) begin
            rsp_valid <= 1'b1;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_key_map_table.sv
// Randomized self-checking bench for key_map_table against an array model of the table.
module tb_key_map_table;

  localparam int K = 7;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic [1:0]   req_op;
  logic [K-1:0] req_key;
  logic [K-1:0] req_data;
  logic         rsp_valid;
  logic [K-1:0] rsp_data;
  logic         rsp_err;
  logic         busy;
  logic         dup_flag;

  int total = 0;
  int bad   = 0;

  logic [K-1:0] mm [K];

  key_map_table #(.KEYS(K)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_key   (req_key),
    .req_data  (req_data),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .dup_flag  (dup_flag)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < K; i++) begin
      mm[i]    = '0;
      mm[i][i] = 1'b1;
    end
  endfunction

  function automatic int idx_of(input logic [K-1:0] v);
    int r;
    r = 0;
    for (int i = 0; i < K; i++) if (v[i]) r = i;
    return r;
  endfunction

  // Entries are always one-hot, so the table is a permutation iff together they cover every note.
  function automatic logic exp_dup();
    logic [K-1:0] acc;
    acc = '0;
    for (int i = 0; i < K; i++) acc |= mm[i];
    return acc != '1;
  endfunction

  function automatic logic [K-1:0] rand_bus();
    logic [K-1:0] v;
    if ($urandom_range(0, 7) == 0) v = K'($urandom);
    else begin
      v = '0;
      v[$urandom_range(0, K - 1)] = 1'b1;
    end
    return v;
  endfunction

  // Issue one request, predict its response from the model, and check latency, busy time and payload.
  task automatic run_op(input logic [1:0] op, input logic [K-1:0] key, input logic [K-1:0] data);
    logic [K-1:0] exp_d, t;
    logic         exp_e, bad_req;
    int           exp_lat, exp_busy, lat, busy_n, n, a, b;
    bad_req  = ((op != 2'b11) && ($countones(key) != 1)) ||
               (((op == 2'b01) || (op == 2'b10)) && ($countones(data) != 1));
    exp_e    = 1'b0;
    exp_d    = '0;
    exp_lat  = 1;
    exp_busy = 0;
    if (bad_req) exp_e = 1'b1;
    else begin
      case (op)
        2'b00: exp_d = mm[idx_of(key)];
        2'b01: begin
          mm[idx_of(key)] = data;
          exp_d = data;
        end
        2'b10: begin
          a = idx_of(key);
          b = idx_of(data);
          exp_d = mm[a];
          t     = mm[a];
          mm[a] = mm[b];
          mm[b] = t;
          exp_lat  = 2;
          exp_busy = 1;
        end
        default: begin
          model_reset();
          exp_lat  = K + 1;
          exp_busy = K;
        end
      endcase
    end

    req_valid = 1'b1;
    req_op    = op;
    req_key   = key;
    req_data  = data;
    n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 20) check("ready_timeout", n, 0);
    @(posedge clk); #1;
    // A follow-up read stays pending during multi-cycle ops and must not be consumed.
    req_op = 2'b00;
    if (exp_busy == 0) req_valid = 1'b0;

    lat    = 1;
    busy_n = 0;
    while (!rsp_valid && lat < K + 5) begin
      if (busy) begin
        busy_n++;
        check("stall_ready", req_ready, 0);
      end
      @(posedge clk); #1;
      lat++;
    end
    req_valid = 1'b0;
    check($sformatf("lat_op%0d", op), lat, exp_lat);
    check($sformatf("busy_op%0d", op), busy_n, exp_busy);
    check($sformatf("rsp_data_op%0d", op), rsp_data, exp_d);
    check($sformatf("rsp_err_op%0d", op), rsp_err, exp_e);

    @(posedge clk); #1;
    check("rsp_pulse", rsp_valid, 0);
    check("rsp_hold", rsp_data, exp_d);
    check("dup_flag", dup_flag, exp_dup());
  endtask

  // Back-to-back reads of every entry, one per cycle.
  task automatic read_all(input string tag);
    req_valid = 1'b1;
    req_op    = 2'b00;
    req_data  = '0;
    for (int i = 0; i < K; i++) begin
      req_key    = '0;
      req_key[i] = 1'b1;
      @(posedge clk); #1;
      check($sformatf("%s_v%0d", tag, i), rsp_valid, 1);
      check($sformatf("%s_d%0d", tag, i), rsp_data, mm[i]);
      check($sformatf("%s_e%0d", tag, i), rsp_err, 0);
    end
    req_valid = 1'b0;
    @(posedge clk); #1;
    check($sformatf("%s_dup", tag), dup_flag, exp_dup());
  endtask

  task automatic after_reset_checks(input string tag);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    #1;
    check({tag, "_busy"}, busy, 0);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_ready"}, req_ready, 1);
    check({tag, "_dup"}, dup_flag, 0);
    @(posedge clk); #1;
    check({tag, "_no_late_rsp"}, rsp_valid, 0);
    read_all(tag);
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_op    = '0;
    req_key   = '0;
    req_data  = '0;
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_busy", busy, 0);
    check("rst_dup", dup_flag, 0);
    check("rst_ready_low", req_ready, 0);
    rst = 1'b0;
    #1;
    check("ready_after_rst", req_ready, 1);
    read_all("ident");

    run_op(2'b01, 7'b0000100, 7'b1000000);
    run_op(2'b00, 7'b0000100, 7'b0000000);

    run_op(2'b00, 7'b0000011, 7'b0000000);
    run_op(2'b00, 7'b0000000, 7'b0000000);
    run_op(2'b01, 7'b0000001, 7'b0000000);
    run_op(2'b01, 7'b0000001, 7'b0011000);
    run_op(2'b10, 7'b0000001, 7'b0000011);
    read_all("errs");

    run_op(2'b10, 7'b0000001, 7'b0100000);
    read_all("swap");
    run_op(2'b10, 7'b0001000, 7'b0001000);
    read_all("swap_same");

    run_op(2'b01, 7'b0000010, 7'b0000001);
    run_op(2'b01, 7'b1000000, 7'b0000010);
    run_op(2'b01, 7'b0010000, 7'b0010000);
    run_op(2'b11, 7'b0000000, 7'b0000000);
    read_all("restore");

    // Reset while the restore counter is at 3.
    run_op(2'b01, 7'b1000000, 7'b0000001);
    run_op(2'b01, 7'b0010000, 7'b0000010);
    req_valid = 1'b1;
    req_op    = 2'b11;
    req_key   = '0;
    req_data  = '0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rr_busy_before", busy, 1);
    rst = 1'b1;
    #1;
    check("rr_ready_in_rst", req_ready, 0);
    after_reset_checks("rr");

    // Reset the cycle after a swap is accepted.
    run_op(2'b01, 7'b0000010, 7'b0100000);
    req_valid = 1'b1;
    req_op    = 2'b10;
    req_key   = 7'b0000010;
    req_data  = 7'b0010000;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("rs_busy_before", busy, 1);
    rst = 1'b1;
    after_reset_checks("rs");

    for (int n = 0; n < 300; n++) begin
      int r;
      logic [1:0] op;
      r = $urandom_range(0, 15);
      if (r < 6)       op = 2'b00;
      else if (r < 11) op = 2'b01;
      else if (r < 15) op = 2'b10;
      else             op = 2'b11;
      run_op(op, rand_bus(), rand_bus());
    end
    read_all("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
